nonce_search_ctrl: RTL and testbench
====================================

// Module: nonce_search_ctrl
// PURPOSE
//  Sequences one nonce-range search: issues nonces to the SHA-256d hash core, checks
//  each returned hash against the target, and stops on the first hit or on range end.
//  Sits between the config/status registers and the hash core + hash/target compare.
//  Owns range iteration, hash-core handshake, timeout, abort and result capture.
// PARAMETERS
//  NONCE_W     32    nonce width
//  HASH_W      256   hash/target width
//  TIMEOUT_CYC 1024  max cycles in WAIT before error; 0 disables timeout
// PORTS
//  clk              in   1        single clock, rising edge
//  rst_n            in   1        reset, synchronous, active-low
//  cfg_start        in   1        start pulse; sampled only in IDLE
//  cfg_abort        in   1        abort request; any non-IDLE state
//  cfg_target       in   HASH_W   target; latched at start
//  cfg_nonce_first  in   NONCE_W  first nonce; latched at start
//  cfg_nonce_last   in   NONCE_W  last nonce, inclusive; latched at start
//  ctrl_busy        out  1        high in every state except IDLE
//  ctrl_done        out  1        1-cycle pulse at end of any search
//  ctrl_found       out  1        hit seen; held until next accepted start
//  ctrl_err         out  1        hash-core timeout; held until next accepted start
//  golden_nonce     out  NONCE_W  nonce of hit; valid while ctrl_found
//  golden_hash      out  HASH_W   hash of hit; valid while ctrl_found
//  nonce_count      out  32       hashes checked this search; saturates at 2^32-1
//  hc_start         out  1        1-cycle pulse to hash core
//  hc_nonce         out  NONCE_W  nonce to core; stable from hc_start until CHECK
//  hc_done          in   1        core result pulse; ignored outside WAIT
//  hc_hash          in   HASH_W   core result; valid with hc_done
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; golden_*, nonce_count, latched cfg = 0.
//  States: IDLE, ISSUE, WAIT, CHECK.
//  IDLE:  on cfg_start, latch cfg, clear found/err/count, golden_*=0, nonce=first.
//         If first>last (unsigned): ctrl_done pulses next cycle, stay IDLE, count=0.
//         Otherwise go to ISSUE.
//  ISSUE: hc_start=1 for exactly one cycle with hc_nonce=nonce; go to WAIT.
//  WAIT:  on hc_done, register hc_hash, count++ (saturating), go to CHECK.
//         Timeout: TIMEOUT_CYC cycles with no hc_done -> err=1, done pulse, go IDLE.
//  CHECK: hit = registered_hash < target (unsigned, full HASH_W).
//         On hit: golden_nonce=nonce, golden_hash=hash, found=1, done pulse, go IDLE.
//         On nonce==last: done pulse, found=0, go IDLE.
//         Otherwise: nonce=nonce+1, go to ISSUE.
//  Termination test is nonce==last before increment, so last=2^32-1 never wraps.
//  Equality hash==target is NOT a hit.
//  Throughput: 2 + core latency cycles per nonce.
//  Abort:
//   - In ISSUE/WAIT/CHECK: go IDLE next cycle, done pulse, found=0, err=0, count kept.
//   - Abort beats a same-cycle hc_done or hit.
//   - A late hc_done arriving in IDLE is ignored.
//  cfg_start while busy: ignored. Start and abort together in IDLE: start wins.
//  rst_n low mid-search: return to reset values on that clock edge, no done pulse.
// STRUCTURE
//  Package btc_pkg:
//   - NONCE_W and HASH_W constants
//   - state enum typedef
//   - hash_t typedef (HASH_W vector)
//  Sub-module hash_target_cmp: combinational hash<target, fed by registered hash.
//   The controller registers its output in CHECK.
//  FSM, nonce counter, timeout counter and result registers stay in this module.
// TESTING
//  1 first=0x10, last=0x13, target=0x7, core returns 0xF,0x1F,0x3,0xF
//    -> hit at nonce 0x12; golden_hash=0x3; count=3; one done pulse.
//  2 first=5, last=7, every hash=0x1F > target=0x7
//    -> found=0; done after nonce 7; count=3; exactly 3 hc_start pulses.
//  3 first=last=0xFFFFFFFF, hash=0x3
//    -> found=1; golden_nonce=0xFFFFFFFF; single issue; no wrap to 0.
//  4 hash==target==0x7 on nonce 0, last=0
//    -> not a hit; found=0; done pulse.
//  5 abort in same cycle as hc_done(hash=0x1); then a late hc_done while in IDLE
//    -> IDLE, found=0, done pulse, golden_* unchanged at 0.
//  6 core silent with TIMEOUT_CYC=16
//    -> err=1 and done on the 16th WAIT cycle. Also first=9, last=3
//    -> done next cycle, count=0, hc_start never asserted.

Source files
------------

// File: rtl/btc_pkg.sv
// Shared types and widths for the nonce search slice.
//   NONCE_W / HASH_W : nonce and hash/target widths
//   nonce_t / hash_t : vectors of those widths
//   state_t          : search controller states
package btc_pkg;

  localparam int NONCE_W = 32;
  localparam int HASH_W  = 256;

  typedef logic [NONCE_W-1:0] nonce_t;
  typedef logic [HASH_W-1:0]  hash_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK
  } state_t;

endpackage

// File: rtl/nonce_search_ctrl_if.sv
// Hash-core handshake between the search controller (master) and the
// SHA-256d core (slave).
//   hc_start : 1-cycle request pulse, master -> core
//   hc_nonce : nonce to hash, held stable by the master until the result is checked
//   hc_done  : 1-cycle result pulse, core -> master
//   hc_hash  : result hash, valid with hc_done
interface nonce_search_ctrl_if;
  import btc_pkg::*;

  logic   hc_start;
  nonce_t hc_nonce;
  logic   hc_done;
  hash_t  hc_hash;

  modport master (output hc_start, output hc_nonce, input hc_done, input hc_hash);
  modport slave  (input hc_start, input hc_nonce, output hc_done, output hc_hash);

endinterface

// File: rtl/hash_target_cmp.sv
// Combinational hash-vs-target comparator.
//   hash   : registered hash from the core
//   target : latched search target
//   hit    : hash strictly below target (unsigned, full width); equality is no hit
module hash_target_cmp
  import btc_pkg::*;
(
  input  hash_t hash,
  input  hash_t target,
  output logic  hit
);

  assign hit = (hash < target);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce-range search controller: walks nonces first..last (inclusive), issues
// each to the hash core, compares the result with the target and stops on the
// first hit, on range end, on a core timeout or on abort.
//   clk, rst_n          : clock, synchronous active-low reset
//   cfg_start/cfg_abort : start (sampled in IDLE) / abort (any busy state)
//   cfg_target, cfg_nonce_first, cfg_nonce_last : search setup, latched at start
//   ctrl_busy/done/found/err : status; done is a 1-cycle pulse per search
//   golden_nonce/golden_hash : hit result, valid while ctrl_found
//   nonce_count         : hashes checked this search (saturating)
//   hc                  : hash-core handshake (master side)
module nonce_search_ctrl
  import btc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024  // 0 disables the WAIT timeout
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  hash_t       cfg_target,
  input  nonce_t      cfg_nonce_first,
  input  nonce_t      cfg_nonce_last,
  output logic        ctrl_busy,
  output logic        ctrl_done,
  output logic        ctrl_found,
  output logic        ctrl_err,
  output nonce_t      golden_nonce,
  output hash_t       golden_hash,
  output logic [31:0] nonce_count,
  nonce_search_ctrl_if.master hc
);

  state_t      state, state_nxt;
  hash_t       target_q, hash_q;
  nonce_t      last_q, nonce_q;
  logic [31:0] wait_cnt;
  logic        done_q, found_q, err_q;
  logic        hit, abort, empty_range, timeout, is_last;

  hash_target_cmp u_cmp (
    .hash   (hash_q),
    .target (target_q),
    .hit    (hit)
  );

  assign abort       = (state != S_IDLE) && cfg_abort;
  assign empty_range = (cfg_nonce_first > cfg_nonce_last);
  assign timeout     = (TIMEOUT_CYC != 0) && (wait_cnt == TIMEOUT_CYC - 32'd1);
  // Range end is tested before incrementing, so last = all-ones never wraps.
  assign is_last     = (nonce_q == last_q);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides any same-cycle hc_done or hit.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (cfg_start && !empty_range) state_nxt = S_ISSUE;
        S_ISSUE: state_nxt = S_WAIT;
        S_WAIT:  if (hc.hc_done) state_nxt = S_CHECK;
                 else if (timeout) state_nxt = S_IDLE;
        S_CHECK: state_nxt = (hit || is_last) ? S_IDLE : S_ISSUE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state.
  always_comb begin
    ctrl_busy   = (state != S_IDLE);
    hc.hc_start = (state == S_ISSUE);
  end

  assign hc.hc_nonce = nonce_q;
  assign ctrl_done   = done_q;
  assign ctrl_found  = found_q;
  assign ctrl_err    = err_q;

  // Datapath: latched config, nonce iterator, timeout counter, results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q     <= '0;
      last_q       <= '0;
      nonce_q      <= '0;
      hash_q       <= '0;
      wait_cnt     <= '0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      err_q        <= 1'b0;
      golden_nonce <= '0;
      golden_hash  <= '0;
      nonce_count  <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Count is kept; a result arriving this same cycle is dropped.
        done_q  <= 1'b1;
        found_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (cfg_start) begin
              target_q     <= cfg_target;
              last_q       <= cfg_nonce_last;
              nonce_q      <= cfg_nonce_first;
              found_q      <= 1'b0;
              err_q        <= 1'b0;
              nonce_count  <= '0;
              golden_nonce <= '0;
              golden_hash  <= '0;
              if (empty_range) done_q <= 1'b1;
            end
          end
          S_ISSUE: wait_cnt <= '0;
          S_WAIT: begin
            if (hc.hc_done) begin
              hash_q <= hc.hc_hash;
              if (nonce_count != '1) nonce_count <= nonce_count + 32'd1;
            end else if (timeout) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 32'd1;
            end
          end
          S_CHECK: begin
            if (hit) begin
              golden_nonce <= nonce_q;
              golden_hash  <= hash_q;
              found_q      <= 1'b1;
              done_q       <= 1'b1;
            end else if (is_last) begin
              done_q <= 1'b1;
            end else begin
              nonce_q <= nonce_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
module tb_nonce_search_ctrl;
  import btc_pkg::*;

  typedef struct {
    logic        found;
    logic        err;
    nonce_t      gnonce;
    hash_t       ghash;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start, cfg_abort;
  hash_t       cfg_target;
  nonce_t      cfg_nonce_first, cfg_nonce_last;
  logic        ctrl_busy, ctrl_done, ctrl_found, ctrl_err;
  nonce_t      golden_nonce;
  hash_t       golden_hash;
  logic [31:0] nonce_count;

  nonce_search_ctrl_if hc();

  nonce_search_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_start       (cfg_start),
    .cfg_abort       (cfg_abort),
    .cfg_target      (cfg_target),
    .cfg_nonce_first (cfg_nonce_first),
    .cfg_nonce_last  (cfg_nonce_last),
    .ctrl_busy       (ctrl_busy),
    .ctrl_done       (ctrl_done),
    .ctrl_found      (ctrl_found),
    .ctrl_err        (ctrl_err),
    .golden_nonce    (golden_nonce),
    .golden_hash     (golden_hash),
    .nonce_count     (nonce_count),
    .hc              (hc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cnt = 0, done_cnt = 0;
  int last_start_cyc = 0, done_cyc = 0, start_drive_cyc = 0;
  int done_base = 0, start_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hash core model: answers each hc_start core_lat cycles later, or stays silent.
  hash_t core_hashes[$];
  int    core_lat = 1;
  logic  core_silent = 1'b0;
  logic  core_done;
  hash_t core_hash;
  logic  man_done = 1'b0;
  hash_t man_hash = '0;

  assign hc.hc_done = core_done | man_done;
  assign hc.hc_hash = man_done ? man_hash : core_hash;

  initial begin
    core_done = 1'b0;
    core_hash = '0;
    forever begin
      @(negedge clk);
      if (hc.hc_start === 1'b1 && !core_silent) begin
        repeat (core_lat) @(negedge clk);
        if (core_hashes.size() > 0) core_hash = core_hashes.pop_front();
        else core_hash = '1;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
      end
    end
  end

  // Reference model of one search outcome.
  function automatic exp_t model(input nonce_t first, input nonce_t last,
                                 input hash_t target, input hash_t h[$], input logic err);
    exp_t   r;
    nonce_t n;
    r.found = 1'b0; r.err = err; r.gnonce = '0; r.ghash = '0; r.cnt = '0;
    if (first <= last) begin
      n = first;
      for (int i = 0; i < h.size(); i++) begin
        r.cnt = r.cnt + 1;
        if (h[i] < target) begin
          r.found = 1'b1; r.gnonce = n; r.ghash = h[i];
          break;
        end
        if (n == last) break;
        n = n + 1'b1;
      end
    end
    return r;
  endfunction

  // Scoreboard: expected result pushed at start, popped on ctrl_done.
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hc.hc_start) begin
        start_cnt++;
        last_start_cyc = cyc;
      end
      if (ctrl_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("found",        ctrl_found,   e.found);
          check("err",          ctrl_err,     e.err);
          check("golden_nonce", golden_nonce, e.gnonce);
          check("golden_hash",  golden_hash,  e.ghash);
          check("nonce_count",  nonce_count,  e.cnt);
          check("busy_at_done", ctrl_busy,    0);
        end
      end
    end
  end

  hash_t hl[$];

  task automatic start_search(input nonce_t first, input nonce_t last, input hash_t target,
                              input logic exp_err);
    core_hashes = hl;
    sb.push_back(model(first, last, target, hl, exp_err));
    done_base       = done_cnt;
    start_base      = start_cnt;
    cfg_nonce_first = first;
    cfg_nonce_last  = last;
    cfg_target      = target;
    cfg_start       = 1'b1;
    start_drive_cyc = cyc;
    @(negedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == done_base && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == done_base) check(tag, 0, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int d_after;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_target = '0; cfg_nonce_first = '0; cfg_nonce_last = '0;
    repeat (3) @(negedge clk);
    check("rst_flags", {ctrl_busy, ctrl_done, ctrl_found, ctrl_err, hc.hc_start}, 0);
    check("rst_golden_nonce", golden_nonce, 0);
    check("rst_golden_hash", golden_hash, 0);
    check("rst_count", nonce_count, 0);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;

    // 1: hit on the third nonce
    core_lat = 2;
    hl.delete(); hl.push_back(256'hF); hl.push_back(256'h1F); hl.push_back(256'h3); hl.push_back(256'hF);
    start_search(32'h10, 32'h13, 256'h7, 1'b0);
    wait_done("t1_done_timeout");
    check("t1_done_pulses", done_cnt - done_base, 1);

    // 2: no hit over 5..7; a start while busy is ignored
    core_lat = 1;
    hl.delete(); repeat (3) hl.push_back(256'h1F);
    start_search(32'd5, 32'd7, 256'h7, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    cfg_nonce_first = 32'd0; cfg_nonce_last = 32'd0; cfg_start = 1'b1;
    @(negedge clk); #1;
    cfg_start = 1'b0;
    wait_done("t2_done_timeout");
    check("t2_hc_starts", start_cnt - start_base, 3);
    check("t2_last_nonce", hc.hc_nonce, 32'd7);

    // 3: single all-ones nonce, no wrap
    core_lat = 3;
    hl.delete(); hl.push_back(256'h3);
    start_search(32'hFFFF_FFFF, 32'hFFFF_FFFF, 256'h7, 1'b0);
    wait_done("t3_done_timeout");
    check("t3_hc_starts", start_cnt - start_base, 1);
    check("t3_no_wrap", hc.hc_nonce, 32'hFFFF_FFFF);

    // 4: hash equal to target is not a hit
    core_lat = 1;
    hl.delete(); hl.push_back(256'h7);
    start_search(32'd0, 32'd0, 256'h7, 1'b0);
    wait_done("t4_done_timeout");

    // 5: abort beats a same-cycle hc_done; late hc_done in IDLE ignored
    core_silent = 1'b1;
    hl.delete();
    start_search(32'd0, 32'd5, 256'h7, 1'b0);
    for (int n = 0; n < 50 && start_cnt == start_base; n++) begin
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    man_done = 1'b1; man_hash = 256'h1; cfg_abort = 1'b1;
    @(negedge clk); #1;
    man_done = 1'b0; cfg_abort = 1'b0;
    wait_done("t5_done_timeout");
    d_after = done_cnt;
    man_done = 1'b1; man_hash = 256'h1;
    @(negedge clk); #1;
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t5_late_busy", ctrl_busy, 0);
    check("t5_late_found", ctrl_found, 0);
    check("t5_late_golden", golden_hash, 0);
    check("t5_late_count", nonce_count, 0);
    check("t5_late_no_done", done_cnt - d_after, 0);

    // 6a: silent core times out after 16 WAIT cycles
    start_search(32'd0, 32'd0, 256'h7, 1'b1);
    wait_done("t6_done_timeout");
    check("t6_timeout_cycles", done_cyc - last_start_cyc, 17);

    // 6b: empty range completes next cycle without issuing
    core_silent = 1'b0;
    hl.delete();
    start_search(32'd9, 32'd3, 256'h7, 1'b0);
    wait_done("t6b_done_timeout");
    check("t6b_latency", done_cyc - start_drive_cyc, 1);
    check("t6b_hc_starts", start_cnt - start_base, 0);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
